// File: rtl/control_layer1_writeback.sv
// Layer-1 result writeback sequencer: turns a raster stream of result strobes into
// feature-map buffer writes with frame handshake. Optional 2x2 pooling strobe under LAYER1_POOL2X2_EN.
module control_layer1_writeback #(
  parameter int unsigned WIDTH = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic        frame_ack,
  output logic        wr_en,
  output logic [31:0] wr_addr,
  output logic [31:0] out_col,
  output logic [31:0] out_row,
  output logic        last,
  output logic        frame_done,
  output logic        overflow,
  output logic        pool_valid
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] COLLECT = 2'd1;
  localparam logic [1:0] DONE    = 2'd2;

  localparam logic [31:0] LAST_K   = 32'(WIDTH * WIDTH - 1);
  localparam logic [31:0] LAST_COL = 32'(WIDTH - 1);

  logic [1:0]  state;
  logic [31:0] k;
  logic [31:0] col;
  logic [31:0] row;

  logic in_done;
  logic accept;
  logic final_k;

  // In DONE a sample is only taken when the acknowledge arrives in the same cycle.
  always_comb begin
    in_done = (state == DONE);
    accept  = valid_in && (!in_done || frame_ack);
    final_k = (k == LAST_K);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      k          <= '0;
      col        <= '0;
      row        <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      out_col    <= '0;
      out_row    <= '0;
      last       <= 1'b0;
      frame_done <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      wr_en <= accept;
      last  <= accept && final_k;

      if (accept) begin
        wr_addr <= k;
        out_col <= col;
        out_row <= row;
        if (final_k) begin
          k     <= '0;
          col   <= '0;
          row   <= '0;
          state <= DONE;
        end else begin
          k     <= k + 32'd1;
          state <= COLLECT;
          if (col == LAST_COL) begin
            col <= '0;
            row <= row + 32'd1;
          end else begin
            col <= col + 32'd1;
          end
        end
      end else if (in_done && frame_ack) begin
        state <= IDLE;
      end

      // A simultaneous ack+final sample (single-sample frame) keeps frame_done high.
      if (accept && final_k) begin
        frame_done <= 1'b1;
      end else if (in_done && frame_ack) begin
        frame_done <= 1'b0;
      end

      if (in_done && valid_in && !frame_ack) begin
        overflow <= 1'b1;
      end
    end
  end

`ifdef LAYER1_POOL2X2_EN
  assign pool_valid = wr_en & out_row[0] & out_col[0];
`else
  assign pool_valid = 1'b0;
`endif

endmodule

// File: tb/tb_control_layer1_writeback.sv
// Bench for control_layer1_writeback: directed and random stimulus on a WIDTH=5 and a
// WIDTH=4 instance, each checked every cycle against a sample-count reference model.
module tb_control_layer1_writeback;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, valid_a, ack_a;
  logic        wr_en_a, last_a, fd_a, ovf_a, pool_a;
  logic [31:0] addr_a, col_a, row_a;
  logic        rst_b, valid_b, ack_b;
  logic        wr_en_b, last_b, fd_b, ovf_b, pool_b;
  logic [31:0] addr_b, col_b, row_b;

  control_layer1_writeback #(.WIDTH(5)) dut_a (
    .clk(clk), .rst(rst_a), .valid_in(valid_a), .frame_ack(ack_a),
    .wr_en(wr_en_a), .wr_addr(addr_a), .out_col(col_a), .out_row(row_a),
    .last(last_a), .frame_done(fd_a), .overflow(ovf_a), .pool_valid(pool_a)
  );

  control_layer1_writeback #(.WIDTH(4)) dut_b (
    .clk(clk), .rst(rst_b), .valid_in(valid_b), .frame_ack(ack_b),
    .wr_en(wr_en_b), .wr_addr(addr_b), .out_col(col_b), .out_row(row_b),
    .last(last_b), .frame_done(fd_b), .overflow(ovf_b), .pool_valid(pool_b)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model state, index 0 = instance a, 1 = instance b.
  int unsigned side [2] = '{5, 4};
  int unsigned cnt  [2];
  bit          done_m[2], ovf_m[2], fd_m[2], we_m[2], last_m[2], pool_m[2];
  int unsigned addr_m[2], col_m[2], row_m[2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cycle %0d: observed %0d expected %0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_step(input int i, input bit r, input bit v, input bit a);
    bit acc;
    if (r) begin
      cnt[i] = 0; done_m[i] = 0; ovf_m[i] = 0; fd_m[i] = 0;
      we_m[i] = 0; last_m[i] = 0; addr_m[i] = 0; col_m[i] = 0; row_m[i] = 0;
    end else begin
      acc = v && (!done_m[i] || a);
      if (done_m[i] && v && !a) ovf_m[i] = 1;
      if (done_m[i] && a) begin
        done_m[i] = 0;
        fd_m[i]   = 0;
      end
      we_m[i]   = acc;
      last_m[i] = 0;
      if (acc) begin
        addr_m[i] = cnt[i];
        col_m[i]  = cnt[i] % side[i];
        row_m[i]  = cnt[i] / side[i];
        if (cnt[i] == side[i] * side[i] - 1) begin
          last_m[i] = 1;
          done_m[i] = 1;
          fd_m[i]   = 1;
          cnt[i]    = 0;
        end else begin
          cnt[i] = cnt[i] + 1;
        end
      end
    end
`ifdef LAYER1_POOL2X2_EN
    pool_m[i] = we_m[i] && (row_m[i] % 2 == 1) && (col_m[i] % 2 == 1);
`else
    pool_m[i] = 0;
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(0, rst_a, valid_a, ack_a);
    model_step(1, rst_b, valid_b, ack_b);
    cyc++;
    #1;
    check("a.wr_en", {31'd0, wr_en_a}, {31'd0, we_m[0]});
    check("a.last", {31'd0, last_a}, {31'd0, last_m[0]});
    check("a.frame_done", {31'd0, fd_a}, {31'd0, fd_m[0]});
    check("a.overflow", {31'd0, ovf_a}, {31'd0, ovf_m[0]});
    check("a.pool_valid", {31'd0, pool_a}, {31'd0, pool_m[0]});
    check("a.wr_addr", addr_a, addr_m[0]);
    check("a.out_col", col_a, col_m[0]);
    check("a.out_row", row_a, row_m[0]);
    check("b.wr_en", {31'd0, wr_en_b}, {31'd0, we_m[1]});
    check("b.last", {31'd0, last_b}, {31'd0, last_m[1]});
    check("b.frame_done", {31'd0, fd_b}, {31'd0, fd_m[1]});
    check("b.overflow", {31'd0, ovf_b}, {31'd0, ovf_m[1]});
    check("b.pool_valid", {31'd0, pool_b}, {31'd0, pool_m[1]});
    check("b.wr_addr", addr_b, addr_m[1]);
    check("b.out_col", col_b, col_m[1]);
    check("b.out_row", row_b, row_m[1]);
  endtask

  task automatic drive_a(input bit r, input bit v, input bit a, input int n);
    rst_a = r; valid_a = v; ack_a = a;
    for (int i = 0; i < n; i++) tick();
    rst_a = 0; valid_a = 0; ack_a = 0;
  endtask

  task automatic drive_b(input bit r, input bit v, input bit a, input int n);
    rst_b = r; valid_b = v; ack_b = a;
    for (int i = 0; i < n; i++) tick();
    rst_b = 0; valid_b = 0; ack_b = 0;
  endtask

  // n samples on instance a, one every 'gap' cycles.
  task automatic samples_a(input int n, input int gap);
    for (int s = 0; s < n; s++) begin
      drive_a(0, 1, 0, 1);
      if (gap > 1) drive_a(0, 0, 0, gap - 1);
    end
  endtask

  initial begin
    rst_a = 1; valid_a = 0; ack_a = 0;
    rst_b = 1; valid_b = 0; ack_b = 0;
    tick(); tick();
    rst_a = 0; rst_b = 0;
    tick();

    // Full back-to-back frame, then frame_done must hold without ack.
    samples_a(25, 1);
    drive_a(0, 0, 0, 4);
    // Ack and new sample together: accepted as k=0, no overflow.
    drive_a(0, 1, 1, 1);
    samples_a(24, 3);
    // Samples while DONE without ack are dropped and raise overflow.
    drive_a(0, 1, 0, 3);
    drive_a(0, 0, 0, 2);
    drive_a(0, 0, 1, 1);
    drive_a(0, 0, 0, 2);
    // Ack outside DONE is ignored.
    drive_a(0, 0, 1, 2);
    // Sparse frame after reset: wraps at 5, 10, 15, 20.
    drive_a(1, 0, 0, 1);
    samples_a(25, 3);
    drive_a(0, 0, 1, 1);
    // Mid-frame reset discards the partial frame.
    samples_a(12, 1);
    drive_a(1, 1, 1, 1);
    samples_a(25, 1);
    drive_a(0, 0, 1, 1);

    // WIDTH=4 frame for the pooling strobe.
    drive_b(0, 1, 0, 16);
    drive_b(0, 0, 0, 2);
    drive_b(0, 1, 1, 1);
    drive_b(0, 1, 0, 15);
    drive_b(0, 0, 1, 1);

    // Random traffic on both instances.
    for (int i = 0; i < 600; i++) begin
      rst_a   = ($urandom_range(0, 79) == 0);
      valid_a = $urandom_range(0, 2) != 0;
      ack_a   = ($urandom_range(0, 3) == 0);
      rst_b   = ($urandom_range(0, 79) == 0);
      valid_b = $urandom_range(0, 2) != 0;
      ack_b   = ($urandom_range(0, 3) == 0);
      tick();
    end
    rst_a = 0; valid_a = 0; ack_a = 0;
    rst_b = 0; valid_b = 0; ack_b = 0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
